// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer.
// - state_t   : sequencer FSM state encoding (idle, fetch, play)
// - dur_lsb   : bit offset of the duration field in a packed {freq, dur} pattern entry;
//               the frequency field sits directly above it
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StPlay  = 2'd2
    } state_t;

    localparam int unsigned dur_lsb = 0;

endpackage

// File: rtl/note_sequencer_tick_prescaler.sv
// Tempo prescaler: counts 0..tick_div-1 while enabled and pulses tick on the
// cycle the count wraps.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   clear  in  synchronous clear of the count (wins over enable)
//   enable in  count enable
//   tick   out high on the last cycle of each tick_div-cycle period
module note_sequencer_tick_prescaler #(
    parameter int unsigned tick_div = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned cnt_width = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam logic [cnt_width-1:0] max_count = cnt_width'(tick_div - 1);

    logic [cnt_width-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == max_count) begin
                count <= '0;
            end else begin
                count <= count + cnt_width'(1);
            end
        end
    end

    assign tick = enable && (count == max_count);

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: plays a programmed list of {frequency, duration} entries by
// driving the square-wave generator's frequency word and a mute gate.
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   wr_valid/wr_ready      pattern write handshake (accepted only while idle)
//   wr_addr/wr_freq/wr_dur entry index, frequency word (0 = rest), duration in ticks (0 = skip)
//   length, loop           entries to play and loop flag, latched on start
//   start, stop            begin playback from entry 0 / abort playback
//   frequency_control      frequency word to the square-wave generator
//   gate                   high while a non-rest note sounds
//   busy                   high whenever not idle
//   note_strobe            one-cycle pulse on the first play cycle of each note
//   done                   one-cycle pulse when a non-looping sequence ends
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned counter_width  = 8,
    parameter int unsigned duration_width = 8,
    parameter int unsigned depth          = 16,
    parameter int unsigned tick_div       = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [$clog2(depth)-1:0]   wr_addr,
    input  logic [counter_width-1:0]   wr_freq,
    input  logic [duration_width-1:0]  wr_dur,
    input  logic [$clog2(depth):0]     length,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [counter_width-1:0]   frequency_control,
    output logic                       gate,
    output logic                       busy,
    output logic                       note_strobe,
    output logic                       done
);

    localparam int unsigned idx_width   = $clog2(depth);
    localparam int unsigned entry_width = counter_width + duration_width;
    localparam int unsigned freq_lsb    = dur_lsb + duration_width;

    state_t                    state;
    logic [idx_width-1:0]      index;
    logic [idx_width:0]        length_q;
    logic                      loop_q;
    logic [duration_width-1:0] dur_cnt;

    logic [entry_width-1:0]    mem [depth];
    logic [entry_width-1:0]    rd_entry;
    logic [counter_width-1:0]  rd_freq;
    logic [duration_width-1:0] rd_dur;

    logic                      tick;
    logic [idx_width:0]        idx_inc;
    logic                      is_last;
    logic                      adv_end;
    logic [idx_width-1:0]      adv_index;

    assign wr_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    // Pattern memory has no reset so a loaded pattern survives a reset.
    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready) begin
            mem[wr_addr] <= {wr_freq, wr_dur};
        end
    end

    assign rd_entry = mem[index];
    assign rd_freq  = rd_entry[freq_lsb +: counter_width];
    assign rd_dur   = rd_entry[dur_lsb +: duration_width];

    // The index wraps at the latched length, not at the memory depth.
    always_comb begin
        idx_inc   = {1'b0, index} + (idx_width + 1)'(1);
        is_last   = !(idx_inc < length_q);
        adv_end   = is_last && !loop_q;
        adv_index = is_last ? '0 : idx_inc[idx_width-1:0];
    end

    note_sequencer_tick_prescaler #(
        .tick_div (tick_div)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != StPlay),
        .enable (state == StPlay),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= StIdle;
            index             <= '0;
            length_q          <= '0;
            loop_q            <= 1'b0;
            dur_cnt           <= '0;
            frequency_control <= '0;
            gate              <= 1'b0;
            note_strobe       <= 1'b0;
            done              <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state             <= StIdle;
                frequency_control <= '0;
                gate              <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            length_q <= length;
                            loop_q   <= loop;
                            index    <= '0;
                            if (length == '0) begin
                                done <= 1'b1;
                            end else begin
                                state <= StFetch;
                            end
                        end
                    end
                    StFetch: begin
                        if (rd_dur == '0) begin
                            // Skipped entry: outputs keep the previous note.
                            if (adv_end) begin
                                state             <= StIdle;
                                done              <= 1'b1;
                                frequency_control <= '0;
                                gate              <= 1'b0;
                            end else begin
                                index <= adv_index;
                            end
                        end else begin
                            frequency_control <= rd_freq;
                            gate              <= (rd_freq != '0);
                            dur_cnt           <= rd_dur;
                            note_strobe       <= 1'b1;
                            state             <= StPlay;
                        end
                    end
                    StPlay: begin
                        if (tick) begin
                            if (dur_cnt == duration_width'(1)) begin
                                if (adv_end) begin
                                    state             <= StIdle;
                                    done              <= 1'b1;
                                    frequency_control <= '0;
                                    gate              <= 1'b0;
                                end else begin
                                    index <= adv_index;
                                    state <= StFetch;
                                end
                            end else begin
                                dur_cnt <= dur_cnt - duration_width'(1);
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with tick_div=4. Outputs are sampled on the
// falling clock edge; inputs are changed there too and take effect at the next
// rising edge.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [7:0] wr_freq;
    logic [7:0] wr_dur;
    logic [4:0] length;
    logic       loop;
    logic       start;
    logic       stop;
    logic [7:0] frequency_control;
    logic       gate;
    logic       busy;
    logic       note_strobe;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    note_sequencer #(
        .counter_width  (8),
        .duration_width (8),
        .depth          (16),
        .tick_div       (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_addr           (wr_addr),
        .wr_freq           (wr_freq),
        .wr_dur            (wr_dur),
        .length            (length),
        .loop              (loop),
        .start             (start),
        .stop              (stop),
        .frequency_control (frequency_control),
        .gate              (gate),
        .busy              (busy),
        .note_strobe       (note_strobe),
        .done              (done)
    );

    // {frequency_control, gate, busy, note_strobe, done}
    function automatic logic [11:0] outs();
        return {frequency_control, gate, busy, note_strobe, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check n consecutive cycles; strobe is expected only on the first of them.
    task automatic expect_run(input string tag, input int n, input logic [7:0] f,
                              input logic g, input logic b, input logic s_first,
                              input logic d);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(outs()), 32'({f, g, b, (s_first && (i == 0)), d}));
            @(negedge clk);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [7:0] f, input logic [7:0] d);
        wr_addr  = a;
        wr_freq  = f;
        wr_dur   = d;
        wr_valid = 1'b1;
        check("wr_ready_idle", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_freq  = '0;
        wr_dur   = '0;
        length   = '0;
        loop     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_rel_outs", 32'(outs()), 32'd0);

        // Basic three-note sequence with a rest
        write_entry(4'd0, 8'h20, 8'd2);
        write_entry(4'd1, 8'h00, 8'd1);
        write_entry(4'd2, 8'h40, 8'd3);
        length = 5'd3;
        loop   = 1'b0;
        pulse_start();
        expect_run("a_fetch0", 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_run("a_note0", 8, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_run("a_fetch1", 1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_run("a_rest", 4, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_run("a_fetch2", 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_run("a_note2", 12, 8'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_run("a_done", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_run("a_idle", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Skipped entry between two notes
        write_entry(4'd0, 8'h20, 8'd1);
        write_entry(4'd1, 8'h10, 8'd0);
        write_entry(4'd2, 8'h40, 8'd1);
        pulse_start();
        expect_run("b_fetch0", 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_run("b_note0", 4, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_run("b_skip", 2, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_run("b_note2", 4, 8'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_run("b_done", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_run("b_idle", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Looping over two entries, then start/write ignored, then stop
        write_entry(4'd1, 8'h40, 8'd1);
        length = 5'd2;
        loop   = 1'b1;
        pulse_start();
        loop   = 1'b0;
        length = 5'd1;
        expect_run("c_fetch", 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) begin
            expect_run("c_note0", 4, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
            expect_run("c_fetch1", 1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
            expect_run("c_note1", 4, 8'h40, 1'b1, 1'b1, 1'b1, 1'b0);
            expect_run("c_wrap", 1, 8'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("c_pass4", 32'(outs()), 32'({8'h20, 1'b1, 1'b1, 1'b1, 1'b0}));
        start    = 1'b1;
        wr_addr  = 4'd0;
        wr_freq  = 8'h77;
        wr_dur   = 8'd5;
        wr_valid = 1'b1;
        check("c_wr_ready_busy", 32'(wr_ready), 32'd0);
        @(negedge clk);
        start    = 1'b0;
        wr_valid = 1'b0;
        check("c_start_ignored", 32'(outs()), 32'({8'h20, 1'b1, 1'b1, 1'b0, 1'b0}));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        expect_run("c_stopped", 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // start and stop together in idle
        length = 5'd2;
        start  = 1'b1;
        stop   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        expect_run("d_start_stop", 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero-length sequence
        length = 5'd0;
        pulse_start();
        expect_run("e_done", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_run("e_idle", 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-note, then replay entry 0 (unchanged by the rejected write)
        length = 5'd1;
        pulse_start();
        expect_run("f_fetch", 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_run("f_note", 2, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("f_async_outs", 32'(outs()), 32'd0);
        check("f_async_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        check("f_rst_rel", 32'(outs()), 32'd0);
        pulse_start();
        expect_run("f_refetch", 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_run("f_replay", 4, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_run("f_done", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_run("f_idle", 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a programmed list of notes by driving the `frequency_control` input of the `square_wave` generator and a gate that mutes its output. Each pattern entry holds a frequency word and a duration in tempo ticks. Software loads entries through a valid/ready write port while the sequencer is idle, then starts playback once or in a loop. It sits between the control/register side and the audio datapath.

## Interface
- `counter_width`, 8, width of the frequency word; must match `square_wave.counter_width`.
- `duration_width`, 8, width of the per-note duration in ticks.
- `depth`, 16, number of pattern entries; power of two, ≥2.
- `tick_div`, 1000, `clk` cycles per tempo tick; ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  pattern write request.
- `wr_ready`  out  1  write accepted when high with `wr_valid`.
- `wr_addr`  in  $clog2(depth)  entry index.
- `wr_freq`  in  counter_width  entry frequency word; 0 = rest.
- `wr_dur`  in  duration_width  entry duration in ticks; 0 = skip entry.
- `length`  in  $clog2(depth)+1  number of entries to play, 0..depth.
- `loop`  in  1  replay from entry 0 after the last entry.
- `start`  in  1  begin playback from entry 0.
- `stop`  in  1  abort playback.
- `frequency_control`  out  counter_width  to `square_wave`.
- `gate`  out  1  high while a non-rest note sounds.
- `busy`  out  1  high in any state other than IDLE.
- `note_strobe`  out  1  one-cycle pulse on the first PLAY cycle of each played note.
- `done`  out  1  one-cycle pulse when a non-looping sequence ends.

## Operation
- States: IDLE, FETCH, PLAY.
- IDLE: `wr_ready`=1. `wr_valid` writes `{wr_freq, wr_dur}` to `wr_addr` on the clock edge.
- IDLE with `start`: latch `length` and `loop`, index=0, go to FETCH. If latched `length`=0, go to IDLE instead and pulse `done` the next cycle.
- FETCH (1 cycle): read the entry at the index.
  - `dur`=0: advance the index, stay in FETCH. No strobe, outputs unchanged.
  - Otherwise: load `frequency_control`=freq, `gate`=(freq≠0), duration counter=dur, clear the prescaler, go to PLAY.
- PLAY: the duration counter decrements on each prescaler tick. On the tick that brings it to 0, advance the index:
  - index+1 < length: go to FETCH.
  - Last entry with loop: index=0, go to FETCH.
  - Last entry without loop: go to IDLE, pulse `done`, set `frequency_control`=0 and `gate`=0.
- `stop` in any state: go to IDLE on the next edge, `frequency_control`=0, `gate`=0, no `done`. `stop` has priority over `start` and over a tick in the same cycle.
- `start` outside IDLE is ignored. `wr_valid` outside IDLE is not accepted (`wr_ready`=0).
- Changes to `length` or `loop` during playback have no effect until the next `start`.
- Pattern memory is not cleared by reset.

## Timing
- Reset values:
  - `frequency_control`=0, `gate`=0, `busy`=0, `note_strobe`=0, `done`=0, `wr_ready`=1.
  - State IDLE, prescaler and index 0.
- Reset mid-playback: outputs reach reset values asynchronously.
- `start` sampled at edge N: FETCH during cycle N+1. PLAY from N+2, with new `frequency_control`/`gate` and `note_strobe` in that cycle.
- A note with dur=d holds PLAY for exactly d·tick_div cycles. The following FETCH adds 1 cycle, during which `frequency_control`/`gate` keep the previous note's values.
- Each skipped (dur=0) entry costs 1 FETCH cycle.
- `done` is asserted in the first IDLE cycle. `busy` drops in the same cycle.
- Write latency: an entry written at edge N is readable by a FETCH at N+1 or later.
- Index wraps modulo `length`, not `depth`.

## Structure
- Shared header `sequencer_defs.v`: state encoding localparams (IDLE=0, FETCH=1, PLAY=2) and entry field offsets for the packed `{freq, dur}` word.
- Sub-module `tick_prescaler`: counts 0..tick_div-1, pulses `tick` on wrap, synchronous clear input. Built in the style of the existing `counter`.
- Pattern memory: inferred register array inside `note_sequencer`.

## Test plan
- Reset release → all outputs at reset values; `wr_ready`=1; `busy`=0.
- tick_div=4. Load {0x20,2},{0x00,1},{0x40,3}, length=3, loop=0, start →
  - `frequency_control` 0x20 for 8 cycles (gate=1), then rest for 4 cycles (gate=0), then 0x40 for 12 cycles.
  - One-cycle FETCH gaps between notes; `note_strobe` ×3; single `done`; outputs return to 0.
- Entry {0x10,0} between two valid notes → entry skipped in 1 extra cycle, no strobe for it, no glitch on `frequency_control`.
- loop=1, length=2, run 3 passes → index wraps to 0, no `done`. `stop` mid-note → IDLE next cycle, `gate`=0, no `done`.
- Simultaneous `start`+`stop` in IDLE → stays IDLE. `start` during PLAY ignored. `wr_valid` during PLAY not accepted, memory unchanged.
- length=0 start → `done` pulse, no PLAY. Assert `reset` mid-note → outputs 0 immediately; restart plays entry 0.
